// File: rtl/fir_arb_pkg.sv
// Shared types for the FIR stream arbiter: grant states, requester IDs and
// the round-robin pick used in IDLE.
package fir_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    typedef logic src_id_t;

    localparam src_id_t SRC0 = 1'b0;
    localparam src_id_t SRC1 = 1'b1;

    // On a tie the requester that did not win last time gets the FIR.
    function automatic src_id_t rr_pick(input logic    i_v0,
                                        input logic    i_v1,
                                        input src_id_t i_last);
        src_id_t w_pick;
        if (i_v0 && i_v1) begin
            w_pick = (i_last == SRC0) ? SRC1 : SRC0;
        end else if (i_v1) begin
            w_pick = SRC1;
        end else begin
            w_pick = SRC0;
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/fir_arb_tag_fifo.sv
// Tag FIFO holding the owner of every frame currently in flight through the
// shared FIR; the head steers the return stream. DEPTH must be a power of 2.
module fir_arb_tag_fifo
    import fir_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_push,
    input  src_id_t i_push_id,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output src_id_t o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    src_id_t       r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_stream_arbiter.sv
// Shares one FIR between two AXI-Stream requesters with frame-granular
// round-robin, steering results back by tag. FIR_ARB_STATS_EN adds frame counters.
//
// state  | meaning
// IDLE   | FIR input free; arbitrate if a requester is valid and a tag slot is free
// GRANT0 | requester 0 owns the FIR input until its tlast transfer
// GRANT1 | requester 1 owns the FIR input until its tlast transfer
module fir_stream_arbiter
    import fir_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_fir_tdata,
    output logic                  m_axis_fir_tvalid,
    output logic                  m_axis_fir_tlast,
    input  logic                  m_axis_fir_tready,

    input  logic [DATA_WIDTH-1:0] s_axis_fir_tdata,
    input  logic                  s_axis_fir_tvalid,
    input  logic                  s_axis_fir_tlast,
    output logic                  s_axis_fir_tready,

    output logic [DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                  m0_axis_tvalid,
    output logic                  m0_axis_tlast,
    input  logic                  m0_axis_tready,

    output logic [DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                  m1_axis_tvalid,
    output logic                  m1_axis_tlast,
    input  logic                  m1_axis_tready,

    output logic [15:0]           frames0_cnt,
    output logic [15:0]           frames1_cnt
);

    arb_state_t r_state;
    src_id_t    r_last_grant;

    logic    w_any_valid;
    logic    w_tag_full;
    logic    w_tag_empty;
    logic    w_push;
    logic    w_pop;
    logic    w_s0_end;
    logic    w_s1_end;
    src_id_t w_pick;
    src_id_t w_head;

    assign w_any_valid = s0_axis_tvalid || s1_axis_tvalid;
    assign w_pick      = rr_pick(s0_axis_tvalid, s1_axis_tvalid, r_last_grant);
    assign w_push      = (r_state == IDLE) && w_any_valid && !w_tag_full;
    assign w_s0_end    = s0_axis_tvalid && m_axis_fir_tready && s0_axis_tlast;
    assign w_s1_end    = s1_axis_tvalid && m_axis_fir_tready && s1_axis_tlast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= SRC1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_state      <= (w_pick == SRC1) ? GRANT1 : GRANT0;
                        r_last_grant <= w_pick;
                    end
                end
                GRANT0: begin
                    if (w_s0_end) begin
                        r_state <= IDLE;
                    end
                end
                GRANT1: begin
                    if (w_s1_end) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Forward path is a pure mux; the granted requester sees the FIR backpressure.
    always_comb begin
        m_axis_fir_tdata  = '0;
        m_axis_fir_tvalid = 1'b0;
        m_axis_fir_tlast  = 1'b0;
        s0_axis_tready    = 1'b0;
        s1_axis_tready    = 1'b0;
        case (r_state)
            GRANT0: begin
                m_axis_fir_tdata  = s0_axis_tdata;
                m_axis_fir_tvalid = s0_axis_tvalid;
                m_axis_fir_tlast  = s0_axis_tlast;
                s0_axis_tready    = m_axis_fir_tready;
            end
            GRANT1: begin
                m_axis_fir_tdata  = s1_axis_tdata;
                m_axis_fir_tvalid = s1_axis_tvalid;
                m_axis_fir_tlast  = s1_axis_tlast;
                s1_axis_tready    = m_axis_fir_tready;
            end
            default: begin
                m_axis_fir_tdata  = '0;
                m_axis_fir_tvalid = 1'b0;
                m_axis_fir_tlast  = 1'b0;
            end
        endcase
    end

    fir_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_push_id (w_pick),
        .i_pop     (w_pop),
        .o_full    (w_tag_full),
        .o_empty   (w_tag_empty),
        .o_head    (w_head)
    );

    // Return path: with no frame outstanding the FIR output is simply stalled.
    always_comb begin
        m0_axis_tdata     = s_axis_fir_tdata;
        m0_axis_tlast     = s_axis_fir_tlast;
        m1_axis_tdata     = s_axis_fir_tdata;
        m1_axis_tlast     = s_axis_fir_tlast;
        m0_axis_tvalid    = 1'b0;
        m1_axis_tvalid    = 1'b0;
        s_axis_fir_tready = 1'b0;
        if (!w_tag_empty) begin
            if (w_head == SRC1) begin
                m1_axis_tvalid    = s_axis_fir_tvalid;
                s_axis_fir_tready = m1_axis_tready;
            end else begin
                m0_axis_tvalid    = s_axis_fir_tvalid;
                s_axis_fir_tready = m0_axis_tready;
            end
        end
    end

    assign w_pop = s_axis_fir_tvalid && s_axis_fir_tready && s_axis_fir_tlast;

`ifdef FIR_ARB_STATS_EN
    logic [15:0] r_frames0_cnt;
    logic [15:0] r_frames1_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frames0_cnt <= '0;
            r_frames1_cnt <= '0;
        end else if (w_pop) begin
            if (w_head == SRC1) begin
                r_frames1_cnt <= r_frames1_cnt + 16'd1;
            end else begin
                r_frames0_cnt <= r_frames0_cnt + 16'd1;
            end
        end
    end

    assign frames0_cnt = r_frames0_cnt;
    assign frames1_cnt = r_frames1_cnt;
`else
    assign frames0_cnt = '0;
    assign frames1_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Scoreboard bench for fir_stream_arbiter: per-requester source queues, a
// loopback FIR model, and expected FIR-input / return queues.
module tb_fir_stream_arbiter;

    localparam int DW = 16;
    localparam logic [DW-1:0] FIR_XOR = 16'hA5C3;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_fir_tdata, s_axis_fir_tdata;
    logic [DW-1:0] m0_axis_tdata, m1_axis_tdata;
    logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
    logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
    logic          m_axis_fir_tvalid, m_axis_fir_tlast, m_axis_fir_tready;
    logic          s_axis_fir_tvalid, s_axis_fir_tlast, s_axis_fir_tready;
    logic          m0_axis_tvalid, m0_axis_tlast, m0_axis_tready;
    logic          m1_axis_tvalid, m1_axis_tlast, m1_axis_tready;
    logic [15:0]   frames0_cnt, frames1_cnt;

    fir_stream_arbiter #(.DATA_WIDTH(DW), .TAG_DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .s0_axis_tdata     (s0_axis_tdata),
        .s0_axis_tvalid    (s0_axis_tvalid),
        .s0_axis_tlast     (s0_axis_tlast),
        .s0_axis_tready    (s0_axis_tready),
        .s1_axis_tdata     (s1_axis_tdata),
        .s1_axis_tvalid    (s1_axis_tvalid),
        .s1_axis_tlast     (s1_axis_tlast),
        .s1_axis_tready    (s1_axis_tready),
        .m_axis_fir_tdata  (m_axis_fir_tdata),
        .m_axis_fir_tvalid (m_axis_fir_tvalid),
        .m_axis_fir_tlast  (m_axis_fir_tlast),
        .m_axis_fir_tready (m_axis_fir_tready),
        .s_axis_fir_tdata  (s_axis_fir_tdata),
        .s_axis_fir_tvalid (s_axis_fir_tvalid),
        .s_axis_fir_tlast  (s_axis_fir_tlast),
        .s_axis_fir_tready (s_axis_fir_tready),
        .m0_axis_tdata     (m0_axis_tdata),
        .m0_axis_tvalid    (m0_axis_tvalid),
        .m0_axis_tlast     (m0_axis_tlast),
        .m0_axis_tready    (m0_axis_tready),
        .m1_axis_tdata     (m1_axis_tdata),
        .m1_axis_tvalid    (m1_axis_tvalid),
        .m1_axis_tlast     (m1_axis_tlast),
        .m1_axis_tready    (m1_axis_tready),
        .frames0_cnt       (frames0_cnt),
        .frames1_cnt       (frames1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    beat_t src_q0[$], src_q1[$], exp_fir[$], exp_ret0[$], exp_ret1[$], fir_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          fir_in_cnt = 0;
    int          v0_cyc = -1;
    int          r0_cyc = -1;
    logic [14:0] seq = '0;
    logic [15:0] exp_frames0 = '0;
    logic [15:0] exp_frames1 = '0;
    logic        fir_en = 1'b1;
    logic        bp_en = 1'b0;
    logic        tog_en = 1'b0;
    logic        track_lat = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, expv, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Frames are queued in the order arbitration is predicted to serve them.
    task automatic send_frame(input int src, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.last = (i == len - 1);
            b.data = {src[0], seq};
            seq    = seq + 15'd1;
            exp_fir.push_back(b);
            if (src == 0) begin
                src_q0.push_back(b);
                exp_ret0.push_back({b.last, b.data ^ FIR_XOR});
            end else begin
                src_q1.push_back(b);
                exp_ret1.push_back({b.last, b.data ^ FIR_XOR});
            end
        end
    endtask

    task automatic flush();
        src_q0.delete();
        src_q1.delete();
        exp_fir.delete();
        exp_ret0.delete();
        exp_ret1.delete();
        fir_q.delete();
        exp_frames0 = '0;
        exp_frames1 = '0;
        fir_in_cnt  = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush();
        step(2);
        reset = 1'b0;
    endtask

    function automatic int pending();
        return src_q0.size() + src_q1.size() + exp_fir.size() +
               exp_ret0.size() + exp_ret1.size() + fir_q.size();
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, pending(), 0);
    endtask

    // Drive at the falling edge, then sample the settled handshakes that the
    // next rising edge will act on.
    initial begin : engine
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (src_q0.size() != 0) begin
                s0_axis_tvalid = 1'b1;
                {s0_axis_tlast, s0_axis_tdata} = src_q0[0];
            end else begin
                s0_axis_tvalid = 1'b0;
                s0_axis_tlast  = 1'b0;
                s0_axis_tdata  = '0;
            end
            if (src_q1.size() != 0) begin
                s1_axis_tvalid = 1'b1;
                {s1_axis_tlast, s1_axis_tdata} = src_q1[0];
            end else begin
                s1_axis_tvalid = 1'b0;
                s1_axis_tlast  = 1'b0;
                s1_axis_tdata  = '0;
            end
            if (fir_en && fir_q.size() != 0) begin
                s_axis_fir_tvalid = 1'b1;
                {s_axis_fir_tlast, s_axis_fir_tdata} = fir_q[0];
            end else begin
                s_axis_fir_tvalid = 1'b0;
                s_axis_fir_tlast  = 1'b0;
                s_axis_fir_tdata  = '0;
            end
            if (bp_en) begin
                m_axis_fir_tready = 1'($urandom_range(0, 1));
                m0_axis_tready    = 1'($urandom_range(0, 1));
                m1_axis_tready    = 1'($urandom_range(0, 1));
            end
            if (tog_en) m1_axis_tready = ~m1_axis_tready;
            #1;
            if (!reset) begin
                chk("one_grant", 32'(s0_axis_tready && s1_axis_tready), 0);
                if (tog_en && s_axis_fir_tvalid)
                    chk("fir_rdy_mirror", 32'(s_axis_fir_tready), 32'(m1_axis_tready));
                if (track_lat) begin
                    if (s0_axis_tvalid && v0_cyc < 0) v0_cyc = cyc;
                    if (s0_axis_tready && r0_cyc < 0) r0_cyc = cyc;
                end
                if (s0_axis_tvalid && s0_axis_tready) void'(src_q0.pop_front());
                if (s1_axis_tvalid && s1_axis_tready) void'(src_q1.pop_front());
                if (m_axis_fir_tvalid && m_axis_fir_tready) begin
                    chk("fir_in_pending", 32'(exp_fir.size() != 0), 1);
                    if (exp_fir.size() != 0) begin
                        e = exp_fir.pop_front();
                        chk("fir_in", 32'({m_axis_fir_tlast, m_axis_fir_tdata}), 32'(e));
                    end
                    fir_q.push_back({m_axis_fir_tlast, m_axis_fir_tdata ^ FIR_XOR});
                    fir_in_cnt++;
                end
                if (s_axis_fir_tvalid && s_axis_fir_tready) begin
                    chk("ret_one_dest", 32'(m0_axis_tvalid) + 32'(m1_axis_tvalid), 1);
                    void'(fir_q.pop_front());
                end
                if (m0_axis_tvalid && m0_axis_tready) begin
                    chk("ret0_pending", 32'(exp_ret0.size() != 0), 1);
                    if (exp_ret0.size() != 0) begin
                        e = exp_ret0.pop_front();
                        chk("ret0", 32'({m0_axis_tlast, m0_axis_tdata}), 32'(e));
                    end
`ifdef FIR_ARB_STATS_EN
                    if (m0_axis_tlast) exp_frames0++;
`endif
                end
                if (m1_axis_tvalid && m1_axis_tready) begin
                    chk("ret1_pending", 32'(exp_ret1.size() != 0), 1);
                    if (exp_ret1.size() != 0) begin
                        e = exp_ret1.pop_front();
                        chk("ret1", 32'({m1_axis_tlast, m1_axis_tdata}), 32'(e));
                    end
`ifdef FIR_ARB_STATS_EN
                    if (m1_axis_tlast) exp_frames1++;
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

    initial begin : tests
        int base;
        int n;
        reset = 1'b1;
        s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s0_axis_tdata = '0;
        s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0; s1_axis_tdata = '0;
        s_axis_fir_tvalid = 1'b0; s_axis_fir_tlast = 1'b0; s_axis_fir_tdata = '0;
        m_axis_fir_tready = 1'b1;
        m0_axis_tready = 1'b1;
        m1_axis_tready = 1'b1;
        step(2);
        chk("rst_s0_rdy", 32'(s0_axis_tready), 0);
        chk("rst_s1_rdy", 32'(s1_axis_tready), 0);
        chk("rst_fir_vld", 32'(m_axis_fir_tvalid), 0);
        chk("rst_ret_rdy", 32'(s_axis_fir_tready), 0);
        chk("rst_frames0", 32'(frames0_cnt), 0);
        chk("rst_frames1", 32'(frames1_cnt), 0);

        // Long single-requester frame, grant latency, returns to m0 only.
        do_reset();
        v0_cyc = -1;
        r0_cyc = -1;
        track_lat = 1'b1;
        send_frame(0, 2048);
        drain("drain_long", 6000);
        track_lat = 1'b0;
        chk("grant_lat", 32'(r0_cyc - v0_cyc), 1);
        chk("fir_in_cnt_long", 32'(fir_in_cnt), 2048);
        chk("frames0_long", 32'(frames0_cnt), 32'(exp_frames0));

        // Both requesters valid from reset, random backpressure everywhere.
        do_reset();
        bp_en = 1'b1;
        send_frame(0, 4);
        send_frame(1, 4);
        send_frame(0, 4);
        drain("drain_rr", 2000);
        bp_en = 1'b0;
        m_axis_fir_tready = 1'b1;
        m0_axis_tready = 1'b1;
        m1_axis_tready = 1'b1;
        step(1);
        chk("frames0_rr", 32'(frames0_cnt), 32'(exp_frames0));
        chk("frames1_rr", 32'(frames1_cnt), 32'(exp_frames1));

        // Tag FIFO full: FIR output held, six one-sample frames offered.
        do_reset();
        fir_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_frame(0, 1);
            send_frame(1, 1);
        end
        step(20);
        chk("full_grants", 32'(fir_in_cnt), 4);
        chk("full_s0_rdy", 32'(s0_axis_tready), 0);
        chk("full_s1_rdy", 32'(s1_axis_tready), 0);
        chk("full_fir_vld", 32'(m_axis_fir_tvalid), 0);
        chk("full_waiting", 32'(src_q0.size() + src_q1.size()), 2);
        fir_en = 1'b1;
        drain("drain_full", 500);
        chk("full_total", 32'(fir_in_cnt), 6);

        // Return to m1 under toggling backpressure.
        do_reset();
        m1_axis_tready = 1'b0;
        tog_en = 1'b1;
        send_frame(1, 4);
        drain("drain_tog", 500);
        tog_en = 1'b0;
        m1_axis_tready = 1'b1;
        step(1);
        chk("frames1_tog", 32'(frames1_cnt), 32'(exp_frames1));

        // Reset mid-frame while requester 1 owns the FIR input.
        fir_en = 1'b0;
        base = fir_in_cnt;
        send_frame(1, 8);
        n = 0;
        while (fir_in_cnt < base + 3 && n < 50) begin
            step(1);
            n++;
        end
        chk("mid_progress", 32'(fir_in_cnt >= base + 3), 1);
        chk("mid_s1_rdy", 32'(s1_axis_tready), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_s0_rdy", 32'(s0_axis_tready), 0);
        chk("rst_mid_s1_rdy", 32'(s1_axis_tready), 0);
        chk("rst_mid_fir_vld", 32'(m_axis_fir_tvalid), 0);
        chk("rst_mid_m0_vld", 32'(m0_axis_tvalid), 0);
        chk("rst_mid_m1_vld", 32'(m1_axis_tvalid), 0);
        chk("rst_mid_frames0", 32'(frames0_cnt), 0);
        chk("rst_mid_frames1", 32'(frames1_cnt), 0);
        fir_en = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_mid_fir_held", 32'(s_axis_fir_tvalid), 1);
        chk("rst_mid_ret_rdy", 32'(s_axis_fir_tready), 0);
        chk("rst_mid_m1_vld2", 32'(m1_axis_tvalid), 0);
        flush();
        step(2);
        reset = 1'b0;
        send_frame(0, 2);
        send_frame(1, 2);
        drain("drain_post_rst", 500);
        step(1);
        chk("frames0_post", 32'(frames0_cnt), 32'(exp_frames0));
        chk("frames1_post", 32'(frames1_cnt), 32'(exp_frames1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
